// File: rtl/rs_chien_mc.sv
// GF(2^m) field definition and arithmetic helpers shared by the RS decoder blocks,
// followed by the iterative, multi-cycle Chien search.
package gf_pkg;
  localparam int SYMB_WIDTH = 8;
  localparam int T_LEN      = 8;
  localparam logic [SYMB_WIDTH:0] FIELD_POLY = 9'h11D;

  function automatic logic [SYMB_WIDTH-1:0] gf_mult(input logic [SYMB_WIDTH-1:0] a,
                                                    input logic [SYMB_WIDTH-1:0] b);
    logic [SYMB_WIDTH-1:0] acc;
    logic [SYMB_WIDTH-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) acc = acc ^ sh;
      if (sh[SYMB_WIDTH-1]) sh = {sh[SYMB_WIDTH-2:0], 1'b0} ^ FIELD_POLY[SYMB_WIDTH-1:0];
      else                  sh = {sh[SYMB_WIDTH-2:0], 1'b0};
    end
    return acc;
  endfunction

  // alpha^e by square-and-multiply, so constant evaluation stays short for any e
  function automatic logic [SYMB_WIDTH-1:0] alpha_to_symb(input int unsigned e);
    logic [SYMB_WIDTH-1:0] acc;
    logic [SYMB_WIDTH-1:0] base;
    int unsigned ee;
    acc  = {{(SYMB_WIDTH-1){1'b0}}, 1'b1};
    base = {{(SYMB_WIDTH-2){1'b0}}, 2'b10};
    ee   = e % ((32'd1 << SYMB_WIDTH) - 32'd1);
    for (int i = 0; i < 32; i++) begin
      if (ee[i]) acc = gf_mult(acc, base);
      base = gf_mult(base, base);
    end
    return acc;
  endfunction
endpackage

// Chien search: evaluates Lambda(alpha^j) for j = 0..N_LEN-1, ROOTS_PER_CYCLE per cycle.
// Latency CHUNKS cycles from accept to result valid; one transaction in flight.
// Input ready only in IDLE; result held stable in DONE until error_positions_out_rdy.
module rs_chien_mc #(
  parameter  int T_LEN           = gf_pkg::T_LEN,
  parameter  int ROOTS_PER_CYCLE = 16,
  parameter  int N_LEN           = (1 << gf_pkg::SYMB_WIDTH) - 1,
  localparam int SW              = gf_pkg::SYMB_WIDTH,
  localparam int R               = ROOTS_PER_CYCLE,
  localparam int CHUNKS          = (N_LEN + R - 1) / R,
  localparam int CW              = (CHUNKS > 1) ? $clog2(CHUNKS) : 1,
  localparam int CNT_W           = $clog2(T_LEN + 2)
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [T_LEN:0][SW-1:0]      error_locator,
  input  logic                        error_locator_vld,
  output logic                        error_locator_rdy,
  output logic [T_LEN-1:0][SW-1:0]    error_positions,
  output logic [T_LEN-1:0]            error_positions_vld,
  output logic [CNT_W-1:0]            error_cnt,
  output logic                        error_positions_out_vld,
  input  logic                        error_positions_out_rdy,
  output logic                        rs_chien_err
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [T_LEN:0][SW-1:0]   t_q;
  logic [CW-1:0]            c_q;
  logic [T_LEN-1:0][SW-1:0] pos_q, pos_d;
  logic [T_LEN-1:0]         pvld_q, pvld_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         deg_q, deg_in;
  logic                     lam0_zero_q;
  logic                     err_q, err_d;
  logic [R-1:0]             hit;
  logic                     accept, last_chunk, zero_poly;
  logic [SW-1:0]            s_acc;
  int                       j_int;
  int                       n_found;

  assign accept     = (state_q == S_IDLE) && error_locator_vld;
  assign last_chunk = (c_q == CW'(CHUNKS - 1));
  // An all-zero locator vanishes everywhere; it must report no roots at all.
  assign zero_poly  = lam0_zero_q && (deg_q == '0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (error_locator_vld)       state_d = S_SEARCH;
      S_SEARCH: if (last_chunk)              state_d = S_DONE;
      S_DONE:   if (error_positions_out_rdy) state_d = S_IDLE;
      default:                               state_d = S_IDLE;
    endcase
  end

  always_comb begin
    error_locator_rdy       = 1'b0;
    error_positions_out_vld = 1'b0;
    case (state_q)
      S_IDLE:  error_locator_rdy       = 1'b1;
      S_DONE:  error_positions_out_vld = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    deg_in = '0;
    for (int k = 1; k <= T_LEN; k++) begin
      if (error_locator[k] != '0) deg_in = CNT_W'(k);
    end
  end

  // Candidate r of the current chunk: S_r = sum_k t_k * alpha^(k*r), constant multipliers.
  always_comb begin
    hit   = '0;
    s_acc = '0;
    j_int = 0;
    for (int r = 0; r < R; r++) begin
      s_acc = '0;
      for (int k = 0; k <= T_LEN; k++) begin
        s_acc = s_acc ^ gf_pkg::gf_mult(t_q[k], gf_pkg::alpha_to_symb(unsigned'(k * r)));
      end
      j_int  = int'(c_q) * R + r;
      hit[r] = (s_acc == '0) && (j_int < N_LEN) && !zero_poly;
    end
  end

  // Pack hits in ascending order into the next free slots; count saturates at T_LEN+1.
  always_comb begin
    pos_d   = pos_q;
    pvld_d  = pvld_q;
    n_found = int'(cnt_q);
    for (int r = 0; r < R; r++) begin
      if (hit[r]) begin
        for (int s = 0; s < T_LEN; s++) begin
          if (n_found == s) begin
            pos_d[s]  = SW'(int'(c_q) * R + r);
            pvld_d[s] = 1'b1;
          end
        end
        if (n_found < T_LEN + 1) n_found = n_found + 1;
      end
    end
    cnt_d = CNT_W'(n_found);
    err_d = lam0_zero_q || (deg_q == '0) || (cnt_d != deg_q);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      t_q         <= '0;
      c_q         <= '0;
      pos_q       <= '0;
      pvld_q      <= '0;
      cnt_q       <= '0;
      deg_q       <= '0;
      lam0_zero_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (accept) begin
      t_q         <= error_locator;
      c_q         <= '0;
      pos_q       <= '0;
      pvld_q      <= '0;
      cnt_q       <= '0;
      deg_q       <= deg_in;
      lam0_zero_q <= (error_locator[0] == '0);
      err_q       <= 1'b0;
    end else if (state_q == S_SEARCH) begin
      for (int k = 0; k <= T_LEN; k++) begin
        t_q[k] <= gf_pkg::gf_mult(t_q[k], gf_pkg::alpha_to_symb(unsigned'(k * R)));
      end
      pos_q  <= pos_d;
      pvld_q <= pvld_d;
      cnt_q  <= cnt_d;
      if (last_chunk) err_q <= err_d;
      else            c_q   <= c_q + CW'(1);
    end
  end

  assign error_positions     = pos_q;
  assign error_positions_vld = pvld_q;
  assign error_cnt           = cnt_q;
  assign rs_chien_err        = err_q;

endmodule
